fd_acam_bus_ctrl: RTL and testbench
===================================

Name: fd_acam_bus_ctrl

Overview:
- Sequences and arbitrates the ACAM TDC parallel host bus (address, 28-bit data, CS/WR/RD strobes) between two requesters.
- Requesters: the timestamp readout engine (reads results while the empty flag is low) and the Wishbone-side host configuration port (TDC register writes/reads).
- Generates strobe timing with programmable wait states and bus turnaround.
- Guarantees bounded host latency under continuous readout load.

Parameters:
- g_rd_wait, 3: cycles RD_N is held low; data sampled on the last of them (1..15).
- g_wr_wait, 2: cycles WR_N is held low (1..15).
- g_turnaround, 1: idle cycles after each access before the next grant (0..7).
- g_max_ro_burst, 4: consecutive readout grants allowed while a host request is pending (1..15).

Ports:
- clk_sys_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- host_req_i  in  1  host request, level, held until host_ack_o
- host_we_i  in  1  1 = write, 0 = read
- host_adr_i  in  4  host ACAM register address
- host_dat_i  in  28  host write data
- host_ack_o  out  1  one-cycle completion pulse
- host_dat_o  out  28  host read data, valid with host_ack_o
- ro_req_i  in  1  readout request (read only), level, held until ro_ack_o
- ro_adr_i  in  4  readout register address
- ro_ack_o  out  1  one-cycle completion pulse
- ro_dat_o  out  28  readout data, valid with ro_ack_o
- acam_a_o  out  4  ACAM address
- acam_d_o  out  28  ACAM write data
- acam_d_i  in  28  ACAM read data
- acam_d_oe_o  out  1  1 = FPGA drives data bus
- acam_cs_n_o  out  1  chip select, active low
- acam_wr_n_o  out  1  write strobe, active low
- acam_rd_n_o  out  1  read strobe, active low
- busy_o  out  1  high in every state except IDLE

Behaviour:
Reset values (next edge with rst_i=1, from any state):
- acam_cs_n_o, acam_wr_n_o, acam_rd_n_o = 1; acam_d_oe_o = 0; acam_a_o = 0; acam_d_o = 0.
- Both acks = 0; both dat_o = 0; busy_o = 0.
- Burst counter = 0; FSM returns to IDLE.
- An in-flight access is aborted without ack.

FSM: IDLE -> SETUP -> STROBE -> HOLD -> TURN -> IDLE. TURN is skipped when g_turnaround = 0.
- IDLE: strobes high; arbitrate on the registered edge.
  - Address, data and we are latched at grant; later changes on the request inputs are ignored until ack.
- SETUP (1 cycle): cs_n = 0; a_o = latched address; writes also drive d_o with oe = 1.
- STROBE (g_wr_wait or g_rd_wait cycles): wr_n or rd_n = 0; cs_n = 0.
  - Reads capture acam_d_i into the granted requester's dat_o register on the final STROBE cycle.
- HOLD (1 cycle): strobes high, cs_n = 0, oe still held for writes; the granted ack pulses.
- TURN (g_turnaround cycles): cs_n = 1, oe = 0, no grant.

Latency (req sampled high in IDLE at cycle 0):
- Ack at cycle 2 + wait.
- Next grant is possible at cycle 3 + wait + g_turnaround.
- Defaults: read ack at cycle 5; write ack at cycle 4.

Arbitration:
- Readout has priority over host.
- Each readout grant made while host_req_i is high increments the burst counter.
- When the counter equals g_max_ro_burst and host is pending, host wins the next grant and the counter clears.
- The counter also clears on any host grant and whenever host_req_i is low in IDLE.
- Simultaneous requests with counter below the limit: readout wins.

Other rules:
- Request dropped before ack: the access still completes and ack still pulses; requesters must ignore an unexpected ack.
- WR_N and RD_N are never low simultaneously.
- acam_d_oe_o is never 1 during a read or in TURN/IDLE.
- dat_o holds its value between acks.

Test Plan:
- Host write adr=5, dat=0x5002710, defaults -> cs_n low cycles 1-4, wr_n low cycles 2-3, oe=1 cycles 1-4, host_ack_o at cycle 4, next grant no earlier than cycle 6.
- Host read adr=8 with acam_d_i=0xABCDEF0 on the last STROBE cycle -> rd_n low cycles 2-4, host_dat_o=0xABCDEF0 with ack at cycle 5, oe stays 0.
- ro_req_i and host_req_i held high continuously, g_max_ro_burst=4 -> grant order RO,RO,RO,RO,HOST,RO,RO,RO,RO,HOST; exactly one ack per grant.
- Simultaneous first requests, counter=0 -> readout granted first; host acked after one full readout plus turnaround (cycle 11 with defaults).
- rst_i asserted during STROBE of a write -> next edge all strobes=1, oe=0, no ack; a new request after reset is served normally.
- g_turnaround=0, back-to-back readout -> second SETUP immediately follows HOLD; acks at cycles 5 and 10.

Source files
------------

// File: rtl/fd_acam_bus_ctrl.sv
// ACAM TDC parallel host bus sequencer and arbiter.
//
// Shares the ACAM address/data bus between the timestamp readout engine
// (read-only) and the host configuration port. Every access runs
// SETUP -> STROBE (programmable wait states) -> HOLD -> TURN (bus turnaround).
// Readout has priority, but after g_max_ro_burst consecutive readout grants
// with the host waiting, the host gets the next grant so its latency is bounded.
//
// Ports:
//   clk_sys_i, rst_i                  clock, synchronous active-high reset
//   host_req_i/we/adr/dat -> ack/dat  host register access (level request)
//   ro_req_i/adr -> ro_ack/dat        readout access (level request, read only)
//   acam_a_o, acam_d_o, acam_d_i      ACAM address, write data, read data
//   acam_d_oe_o                       FPGA drives the data bus when 1
//   acam_cs_n_o/wr_n_o/rd_n_o         active-low bus strobes
//   busy_o                            high whenever the sequencer is not idle
module fd_acam_bus_ctrl #(
    parameter int unsigned g_rd_wait      = 3,
    parameter int unsigned g_wr_wait      = 2,
    parameter int unsigned g_turnaround   = 1,
    parameter int unsigned g_max_ro_burst = 4
) (
    input  logic        clk_sys_i,
    input  logic        rst_i,
    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [3:0]  host_adr_i,
    input  logic [27:0] host_dat_i,
    output logic        host_ack_o,
    output logic [27:0] host_dat_o,
    input  logic        ro_req_i,
    input  logic [3:0]  ro_adr_i,
    output logic        ro_ack_o,
    output logic [27:0] ro_dat_o,
    output logic [3:0]  acam_a_o,
    output logic [27:0] acam_d_o,
    input  logic [27:0] acam_d_i,
    output logic        acam_d_oe_o,
    output logic        acam_cs_n_o,
    output logic        acam_wr_n_o,
    output logic        acam_rd_n_o,
    output logic        busy_o
);

    localparam logic [3:0] RdLast   = 4'(g_rd_wait - 1);
    localparam logic [3:0] WrLast   = 4'(g_wr_wait - 1);
    localparam logic [3:0] MaxBurst = 4'(g_max_ro_burst);
    localparam bit         NoTurn   = (g_turnaround == 0);
    localparam logic [3:0] TurnLast = NoTurn ? 4'd0 : 4'(g_turnaround - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StTurn} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  burst_q, burst_d;
    logic        host_sel_q, host_sel_d;
    logic        we_q, we_d;
    logic [3:0]  adr_q, adr_d;
    logic [27:0] wdat_q, wdat_d;
    logic [27:0] host_dat_q, host_dat_d;
    logic [27:0] ro_dat_q, ro_dat_d;

    logic arb_en;
    logic grant_ro;
    logic grant_host;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        burst_d    = burst_q;
        host_sel_d = host_sel_q;
        we_d       = we_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        host_dat_d = host_dat_q;
        ro_dat_d   = ro_dat_q;
        grant_ro   = 1'b0;
        grant_host = 1'b0;

        // Without turnaround the HOLD cycle doubles as the arbitration slot so
        // back-to-back accesses run SETUP straight after HOLD.
        arb_en = (state_q == StIdle) || (NoTurn && (state_q == StHold));

        if (arb_en) begin
            if (!host_req_i) begin
                burst_d = '0;
            end
            if (ro_req_i && !(host_req_i && (burst_q == MaxBurst))) begin
                grant_ro = 1'b1;
                if (host_req_i) begin
                    burst_d = burst_q + 4'd1;
                end
            end else if (host_req_i) begin
                grant_host = 1'b1;
                burst_d    = '0;
            end
        end

        unique case (state_q)
            StIdle: ;
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = we_q ? WrLast : RdLast;
            end
            StStrobe: begin
                if (cnt_q == 4'd0) begin
                    state_d = StHold;
                    if (!we_q) begin
                        if (host_sel_q) begin
                            host_dat_d = acam_d_i;
                        end else begin
                            ro_dat_d = acam_d_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (NoTurn) begin
                    state_d = StIdle;
                end else begin
                    state_d = StTurn;
                    cnt_d   = TurnLast;
                end
            end
            StTurn: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Request inputs are latched here and ignored until the ack.
        if (grant_ro) begin
            state_d    = StSetup;
            host_sel_d = 1'b0;
            we_d       = 1'b0;
            adr_d      = ro_adr_i;
        end else if (grant_host) begin
            state_d    = StSetup;
            host_sel_d = 1'b1;
            we_d       = host_we_i;
            adr_d      = host_adr_i;
            if (host_we_i) begin
                wdat_d = host_dat_i;
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            burst_q    <= '0;
            host_sel_q <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            wdat_q     <= '0;
            host_dat_q <= '0;
            ro_dat_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            burst_q    <= burst_d;
            host_sel_q <= host_sel_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            host_dat_q <= host_dat_d;
            ro_dat_q   <= ro_dat_d;
        end
    end

    logic in_access;

    always_comb begin
        in_access   = (state_q == StSetup) || (state_q == StStrobe) || (state_q == StHold);
        acam_cs_n_o = !in_access;
        acam_wr_n_o = !((state_q == StStrobe) && we_q);
        acam_rd_n_o = !((state_q == StStrobe) && !we_q);
        acam_d_oe_o = in_access && we_q;
        acam_a_o    = adr_q;
        acam_d_o    = wdat_q;
        host_ack_o  = (state_q == StHold) && host_sel_q;
        ro_ack_o    = (state_q == StHold) && !host_sel_q;
        host_dat_o  = host_dat_q;
        ro_dat_o    = ro_dat_q;
        busy_o      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_fd_acam_bus_ctrl.sv
module tb_fd_acam_bus_ctrl;

    localparam int RD_W = 3;
    localparam int WR_W = 2;
    localparam int TURN = 1;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        host_req, host_we;
    logic [3:0]  host_adr;
    logic [27:0] host_dat;
    logic        host_ack;
    logic [27:0] host_dat_o;
    logic        ro_req;
    logic [3:0]  ro_adr;
    logic        ro_ack;
    logic [27:0] ro_dat_o;
    logic [3:0]  acam_a;
    logic [27:0] acam_d, acam_di;
    logic        oe, cs_n, wr_n, rd_n, busy;

    // second instance with zero turnaround
    logic        ro_req2;
    logic        h2_req, h2_we;
    logic [3:0]  h2_adr;
    logic [27:0] h2_dat;
    logic        d2_hack, d2_rack, d2_oe, d2_cs_n, d2_wr_n, d2_rd_n, d2_busy;
    logic [27:0] d2_hdat, d2_rdat, d2_d;
    logic [3:0]  d2_a;

    fd_acam_bus_ctrl #(
        .g_rd_wait(RD_W), .g_wr_wait(WR_W), .g_turnaround(TURN), .g_max_ro_burst(MAXB)
    ) dut (
        .clk_sys_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_adr_i(host_adr),
        .host_dat_i(host_dat), .host_ack_o(host_ack), .host_dat_o(host_dat_o),
        .ro_req_i(ro_req), .ro_adr_i(ro_adr), .ro_ack_o(ro_ack), .ro_dat_o(ro_dat_o),
        .acam_a_o(acam_a), .acam_d_o(acam_d), .acam_d_i(acam_di), .acam_d_oe_o(oe),
        .acam_cs_n_o(cs_n), .acam_wr_n_o(wr_n), .acam_rd_n_o(rd_n), .busy_o(busy)
    );

    fd_acam_bus_ctrl #(
        .g_rd_wait(3), .g_wr_wait(2), .g_turnaround(0), .g_max_ro_burst(4)
    ) dut2 (
        .clk_sys_i(clk), .rst_i(rst),
        .host_req_i(h2_req), .host_we_i(h2_we), .host_adr_i(h2_adr),
        .host_dat_i(h2_dat), .host_ack_o(d2_hack), .host_dat_o(d2_hdat),
        .ro_req_i(ro_req2), .ro_adr_i(4'd7), .ro_ack_o(d2_rack), .ro_dat_o(d2_rdat),
        .acam_a_o(d2_a), .acam_d_o(d2_d), .acam_d_i(acam_di), .acam_d_oe_o(d2_oe),
        .acam_cs_n_o(d2_cs_n), .acam_wr_n_o(d2_wr_n), .acam_rd_n_o(d2_rd_n), .busy_o(d2_busy)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level reference model: an access granted at cycle g
    // occupies bus cycles g+1 .. g+2+wait (SETUP, strobes, HOLD), then
    // TURN cycles; arbitration happens on cycles where the bus is free.
    // ------------------------------------------------------------------
    logic        m_valid = 1'b0;
    logic        m_active = 1'b0;
    logic        m_host, m_we;
    int          m_g;
    int          cyc = 0;
    int          m_burst;
    logic [3:0]  e_adr;
    logic [27:0] e_wdat, e_hdat, e_rdat;

    always @(negedge clk) begin : model_blk
        int   off, w;
        logic idle_now, in_acc, strobe, hold, busy_e;
        off      = cyc - m_g;
        w        = m_we ? WR_W : RD_W;
        idle_now = !m_active || (off > 2 + w + TURN);
        in_acc   = m_active && off >= 1 && off <= 2 + w;
        strobe   = m_active && off >= 2 && off <= 1 + w;
        hold     = m_active && off == 2 + w;
        busy_e   = !idle_now;
        if (m_valid) begin
            check("ctrl{cs,wr,rd,oe,busy,hack,rack}",
                  {cs_n, wr_n, rd_n, oe, busy, host_ack, ro_ack},
                  {!in_acc, !(strobe && m_we), !(strobe && !m_we), in_acc && m_we,
                   busy_e, hold && m_host, hold && !m_host});
            check("acam_a", acam_a, e_adr);
            check("acam_d", acam_d, e_wdat);
            check("host_dat", host_dat_o, e_hdat);
            check("ro_dat", ro_dat_o, e_rdat);
        end
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_host   = 1'b0;
            m_we     = 1'b0;
            m_burst  = 0;
            e_adr    = '0;
            e_wdat   = '0;
            e_hdat   = '0;
            e_rdat   = '0;
        end else if (m_valid) begin
            if (strobe && off == 1 + w && !m_we) begin
                if (m_host) e_hdat = acam_di;
                else        e_rdat = acam_di;
            end
            if (idle_now) begin
                m_active = 1'b0;
                if (!host_req) m_burst = 0;
                if (ro_req && !(host_req && m_burst == MAXB)) begin
                    m_active = 1'b1; m_g = cyc; m_host = 1'b0; m_we = 1'b0;
                    e_adr = ro_adr;
                    if (host_req) m_burst++;
                end else if (host_req) begin
                    m_active = 1'b1; m_g = cyc; m_host = 1'b1; m_we = host_we;
                    e_adr = host_adr;
                    if (host_we) e_wdat = host_dat;
                    m_burst = 0;
                end
            end
        end
        cyc++;
    end

    task automatic settle();
        host_req = 1'b0;
        ro_req   = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    // Host write adr=5: literal cycle-by-cycle strobe pattern.
    task automatic t_host_write();
        logic [6:0] cs_lo, wr_lo, oe_hi, busy_hi, ack_hi;
        cs_lo = 7'b0011110; wr_lo = 7'b0001100; oe_hi = 7'b0011110;
        busy_hi = 7'b0111110; ack_hi = 7'b0010000;
        for (int i = 0; i < 7; i++) begin
            acam_di = 28'($urandom);
            if (i == 0) begin
                host_we = 1'b1; host_adr = 4'd5; host_dat = 28'h5002710; host_req = 1'b1;
            end
            if (i == 5) host_req = 1'b0;
            @(negedge clk);
            check("wr_cs_n", cs_n, !cs_lo[i]);
            check("wr_wr_n", wr_n, !wr_lo[i]);
            check("wr_rd_n", rd_n, 1'b1);
            check("wr_oe", oe, oe_hi[i]);
            check("wr_busy", busy, busy_hi[i]);
            check("wr_ack", host_ack, ack_hi[i]);
            if (i == 2) begin
                check("wr_adr", acam_a, 4'd5);
                check("wr_dat", acam_d, 28'h5002710);
            end
            @(posedge clk); #1;
        end
    endtask

    // Host read adr=8 with the sample value present only on the last strobe cycle.
    task automatic t_host_read();
        logic [7:0] cs_lo, rd_lo, ack_hi;
        cs_lo = 8'b00111110; rd_lo = 8'b00011100; ack_hi = 8'b00100000;
        for (int i = 0; i < 8; i++) begin
            acam_di = (i == 4) ? 28'hABCDEF0 : 28'($urandom);
            if (i == 0) begin
                host_we = 1'b0; host_adr = 4'd8; host_dat = 28'($urandom); host_req = 1'b1;
            end
            if (i == 6) host_req = 1'b0;
            @(negedge clk);
            check("rd_cs_n", cs_n, !cs_lo[i]);
            check("rd_rd_n", rd_n, !rd_lo[i]);
            check("rd_wr_n", wr_n, 1'b1);
            check("rd_oe", oe, 1'b0);
            check("rd_ack", host_ack, ack_hi[i]);
            if (i == 5) check("rd_data", host_dat_o, 28'hABCDEF0);
            @(posedge clk); #1;
        end
    endtask

    // Both requesters held high: expect RO x4 then HOST, twice.
    task automatic t_burst();
        logic [9:0] seq, exp_seq;
        int n, t;
        exp_seq = 10'b1000010000;
        seq = '0; n = 0; t = 0;
        ro_adr = 4'd2; host_we = 1'b1; host_adr = 4'd1; host_dat = 28'h0123456;
        ro_req = 1'b1; host_req = 1'b1;
        while (n < 10 && t < 200) begin
            acam_di = 28'($urandom);
            @(negedge clk);
            if (host_ack || ro_ack) begin
                check("one_ack_per_grant", {host_ack, ro_ack} == 2'b11, 1'b0);
                seq[n] = host_ack;
                n++;
            end
            @(posedge clk); #1;
            t++;
        end
        check("burst_grant_count", n, 10);
        check("burst_grant_order", seq, exp_seq);
        settle();
    endtask

    // Simultaneous first requests: readout first, host write acked at cycle 11.
    task automatic t_simul();
        int ro_at, h_at;
        ro_at = -1; h_at = -1;
        for (int i = 0; i < 14; i++) begin
            acam_di = 28'($urandom);
            if (i == 0) begin
                ro_adr = 4'd9; ro_req = 1'b1;
                host_we = 1'b1; host_adr = 4'd4; host_dat = 28'h00000AA; host_req = 1'b1;
            end
            if (ro_at >= 0) ro_req = 1'b0;
            if (h_at >= 0) host_req = 1'b0;
            @(negedge clk);
            if (ro_ack && ro_at < 0) ro_at = i;
            if (host_ack && h_at < 0) h_at = i;
            @(posedge clk); #1;
        end
        check("simul_ro_ack_cycle", ro_at, 5);
        check("simul_host_ack_cycle", h_at, 11);
        settle();
    endtask

    // Reset during the strobe of a write, then a fresh read.
    task automatic t_reset_abort();
        int acks, rd_at;
        acks = 0; rd_at = -1;
        for (int i = 0; i < 8; i++) begin
            acam_di = 28'($urandom);
            if (i == 0) begin
                host_we = 1'b1; host_adr = 4'd6; host_dat = 28'h7654321; host_req = 1'b1;
            end
            if (i == 2) rst = 1'b1;
            if (i == 3) begin rst = 1'b0; host_req = 1'b0; end
            @(negedge clk);
            if (host_ack) acks++;
            if (i == 3) begin
                check("rst_ctrl{cs,wr,rd,oe,busy,hack,rack}",
                      {cs_n, wr_n, rd_n, oe, busy, host_ack, ro_ack}, 7'b1110000);
                check("rst_host_dat", host_dat_o, 28'h0);
            end
            @(posedge clk); #1;
        end
        check("rst_no_ack", acks, 0);
        for (int i = 0; i < 8; i++) begin
            acam_di = 28'($urandom);
            if (i == 0) begin host_we = 1'b0; host_adr = 4'd3; host_req = 1'b1; end
            if (rd_at >= 0) host_req = 1'b0;
            @(negedge clk);
            if (host_ack && rd_at < 0) rd_at = i;
            @(posedge clk); #1;
        end
        check("post_rst_read_ack_cycle", rd_at, 5);
        settle();
    endtask

    // Zero turnaround: back-to-back readouts, SETUP right after HOLD.
    task automatic t_no_turn();
        int a0, a1;
        a0 = -1; a1 = -1;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) ro_req2 = 1'b1;
            @(negedge clk);
            if (d2_rack) begin
                if (a0 < 0) a0 = i;
                else if (a1 < 0) a1 = i;
            end
            if (i == 5) check("noturn_hold_rd_n", d2_rd_n, 1'b1);
            if (i == 6) check("noturn_setup_cs_n", d2_cs_n, 1'b0);
            if (i == 6) check("noturn_busy", d2_busy, 1'b1);
            @(posedge clk); #1;
        end
        ro_req2 = 1'b0;
        check("noturn_ack0_cycle", a0, 5);
        check("noturn_ack1_cycle", a1, 10);
    endtask

    initial begin
        logic ha, ra;
        rst = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_adr = '0; host_dat = '0;
        ro_req = 1'b0; ro_adr = '0; acam_di = '0;
        ro_req2 = 1'b0; h2_req = 1'b0; h2_we = 1'b0; h2_adr = '0; h2_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_ctrl{cs,wr,rd,oe,busy,hack,rack}",
              {cs_n, wr_n, rd_n, oe, busy, host_ack, ro_ack}, 7'b1110000);
        check("reset_a_d", {acam_a, acam_d}, 32'h0);
        check("reset_dat", {host_dat_o, ro_dat_o}, 56'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        settle();

        t_host_write();
        settle();
        t_host_read();
        settle();
        t_burst();
        t_simul();
        t_reset_abort();
        t_no_turn();
        settle();

        // Randomized traffic with level-request requesters.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ha = host_ack;
            ra = ro_ack;
            @(posedge clk); #1;
            acam_di = 28'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            if (rst) begin
                host_req = 1'b0;
                ro_req   = 1'b0;
            end else begin
                if (host_req) begin
                    if (ha) host_req = 1'b0;
                    else if ($urandom_range(0, 9) == 0) begin
                        host_adr = 4'($urandom); host_dat = 28'($urandom);
                        host_we = 1'($urandom);
                    end else if ($urandom_range(0, 59) == 0) host_req = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    host_we = 1'($urandom); host_adr = 4'($urandom);
                    host_dat = 28'($urandom); host_req = 1'b1;
                end
                if (ro_req) begin
                    if (ra) ro_req = 1'b0;
                    else if ($urandom_range(0, 9) == 0) ro_adr = 4'($urandom);
                    else if ($urandom_range(0, 59) == 0) ro_req = 1'b0;
                end else if ($urandom_range(0, 3) != 0) begin
                    ro_adr = 4'($urandom); ro_req = 1'b1;
                end
            end
        end
        rst = 1'b0;
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
